// File: rtl/biriscv_multiplier_iterative.sv
// Iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU) built around one SLICE_W x SLICE_W
// unsigned multiplier that is reused over NSLICE^2 cycles, then sign-corrected.
module biriscv_multiplier_iterative #(
  parameter int SLICE_W = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        opcode_valid_i,
  input  logic [31:0] opcode_opcode_i,
  input  logic [4:0]  opcode_rd_idx_i,
  input  logic [31:0] opcode_ra_operand_i,
  input  logic [31:0] opcode_rb_operand_i,
  input  logic        flush_i,
  output logic        opcode_ready_o,
  output logic        busy_o,
  output logic        writeback_valid_o,
  output logic [31:0] writeback_value_o,
  output logic [4:0]  writeback_rd_idx_o
);

  localparam int NSLICE = 32 / SLICE_W;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  generate
    if (!(SLICE_W == 8 || SLICE_W == 16 || SLICE_W == 32)) begin : g_badSliceW
      $error("biriscv_multiplier_iterative: SLICE_W must be 8, 16 or 32");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic [31:0]     r_aMag;
  logic [31:0]     r_bMag;
  logic            r_neg;
  logic            r_selHi;
  logic [4:0]      r_rd;
  logic [63:0]     r_acc;
  logic [IDXW-1:0] r_i;
  logic [IDXW-1:0] r_j;

  logic [2:0]  w_funct3;
  logic        w_isMul;
  logic        w_accept;
  logic        w_aSigned;
  logic        w_bSigned;
  logic        w_aNeg;
  logic        w_bNeg;
  logic [31:0] w_aMag;
  logic [31:0] w_bMag;
  logic        w_lastStep;

  assign w_funct3  = opcode_opcode_i[14:12];
  assign w_isMul   = (opcode_opcode_i[6:0] == 7'b0110011) &&
                     (opcode_opcode_i[31:25] == 7'b0000001) &&
                     !opcode_opcode_i[14];
  assign w_accept  = (r_state == ST_IDLE) && opcode_valid_i && w_isMul && !flush_i;

  assign w_aSigned = (w_funct3[1:0] == 2'b01) || (w_funct3[1:0] == 2'b10);
  assign w_bSigned = (w_funct3[1:0] == 2'b01);
  assign w_aNeg    = w_aSigned & opcode_ra_operand_i[31];
  assign w_bNeg    = w_bSigned & opcode_rb_operand_i[31];
  // Two's-complement negation leaves 0x80000000 unchanged, which is its correct magnitude.
  assign w_aMag    = w_aNeg ? (~opcode_ra_operand_i + 32'd1) : opcode_ra_operand_i;
  assign w_bMag    = w_bNeg ? (~opcode_rb_operand_i + 32'd1) : opcode_rb_operand_i;

  assign w_lastStep = (r_i == LAST_IDX) && (r_j == LAST_IDX);

  logic [5:0]           w_aShift;
  logic [5:0]           w_bShift;
  logic [SLICE_W-1:0]   w_aSlice;
  logic [SLICE_W-1:0]   w_bSlice;
  logic [2*SLICE_W-1:0] w_prod;
  logic [6:0]           w_ppShift;
  logic [63:0]          w_pp;
  logic [63:0]          w_result;

  assign w_aShift  = 6'(r_i) * 6'(SLICE_W);
  assign w_bShift  = 6'(r_j) * 6'(SLICE_W);
  assign w_aSlice  = SLICE_W'(r_aMag >> w_aShift);
  assign w_bSlice  = SLICE_W'(r_bMag >> w_bShift);
  assign w_prod    = {{SLICE_W{1'b0}}, w_aSlice} * {{SLICE_W{1'b0}}, w_bSlice};
  assign w_ppShift = (7'(r_i) + 7'(r_j)) * 7'(SLICE_W);
  assign w_pp      = 64'(w_prod) << w_ppShift;
  assign w_result  = r_neg ? (~r_acc + 64'd1) : r_acc;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_stateNext = ST_CALC;
      ST_CALC: begin
        if (flush_i)         w_stateNext = ST_IDLE;
        else if (w_lastStep) w_stateNext = ST_DONE;
      end
      ST_DONE: w_stateNext = ST_IDLE;
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // Operand capture, partial-product accumulation and the one-cycle writeback.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_aMag             <= '0;
      r_bMag             <= '0;
      r_neg              <= 1'b0;
      r_selHi            <= 1'b0;
      r_rd               <= '0;
      r_acc              <= '0;
      r_i                <= '0;
      r_j                <= '0;
      writeback_valid_o  <= 1'b0;
      writeback_value_o  <= '0;
      writeback_rd_idx_o <= '0;
    end else begin
      writeback_valid_o <= 1'b0;
      if (w_accept) begin
        r_aMag  <= w_aMag;
        r_bMag  <= w_bMag;
        r_neg   <= w_aNeg ^ w_bNeg;
        r_selHi <= (w_funct3[1:0] != 2'b00);
        r_rd    <= opcode_rd_idx_i;
        r_acc   <= '0;
        r_i     <= '0;
        r_j     <= '0;
      end else if (r_state == ST_CALC && !flush_i) begin
        r_acc <= r_acc + w_pp;
        if (r_j == LAST_IDX) begin
          r_j <= '0;
          r_i <= r_i + IDXW'(1);
        end else begin
          r_j <= r_j + IDXW'(1);
        end
      end else if (r_state == ST_DONE && !flush_i) begin
        writeback_valid_o  <= 1'b1;
        writeback_value_o  <= r_selHi ? w_result[63:32] : w_result[31:0];
        writeback_rd_idx_o <= r_rd;
      end
    end
  end

  assign opcode_ready_o = (r_state == ST_IDLE);
  assign busy_o         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_biriscv_multiplier_iterative.sv
// Directed bench for the iterative multiplier; three instances (SLICE_W 16/8/32) share stimulus,
// the SLICE_W=16 instance is the primary one checked by every scenario.
module tb_biriscv_multiplier_iterative;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] opcode = '0;
  logic [4:0]  rdIdx = '0;
  logic [31:0] ra = '0;
  logic [31:0] rb = '0;
  logic        flush = 1'b0;

  logic        ready16, busy16, wbValid16;
  logic [31:0] wbValue16;
  logic [4:0]  wbRd16;
  logic        ready8, busy8, wbValid8;
  logic [31:0] wbValue8;
  logic [4:0]  wbRd8;
  logic        ready32, busy32, wbValid32;
  logic [31:0] wbValue32;
  logic [4:0]  wbRd32;

  int nVec = 0;
  int nMis = 0;

  always #5 clk = ~clk;

  biriscv_multiplier_iterative #(.SLICE_W(16)) u_dut (
    .clk_i(clk), .rst_ni(rstN), .opcode_valid_i(valid), .opcode_opcode_i(opcode),
    .opcode_rd_idx_i(rdIdx), .opcode_ra_operand_i(ra), .opcode_rb_operand_i(rb),
    .flush_i(flush), .opcode_ready_o(ready16), .busy_o(busy16),
    .writeback_valid_o(wbValid16), .writeback_value_o(wbValue16), .writeback_rd_idx_o(wbRd16)
  );

  biriscv_multiplier_iterative #(.SLICE_W(8)) u_dut8 (
    .clk_i(clk), .rst_ni(rstN), .opcode_valid_i(valid), .opcode_opcode_i(opcode),
    .opcode_rd_idx_i(rdIdx), .opcode_ra_operand_i(ra), .opcode_rb_operand_i(rb),
    .flush_i(flush), .opcode_ready_o(ready8), .busy_o(busy8),
    .writeback_valid_o(wbValid8), .writeback_value_o(wbValue8), .writeback_rd_idx_o(wbRd8)
  );

  biriscv_multiplier_iterative #(.SLICE_W(32)) u_dut32 (
    .clk_i(clk), .rst_ni(rstN), .opcode_valid_i(valid), .opcode_opcode_i(opcode),
    .opcode_rd_idx_i(rdIdx), .opcode_ra_operand_i(ra), .opcode_rb_operand_i(rb),
    .flush_i(flush), .opcode_ready_o(ready32), .busy_o(busy32),
    .writeback_valid_o(wbValid32), .writeback_value_o(wbValue32), .writeback_rd_idx_o(wbRd32)
  );

  // Present one R-type instruction for exactly one edge (edge 0); returns just after edge 0.
  task automatic issue(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    valid  = 1'b1;
    opcode = {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    rdIdx  = rd;
    ra     = a;
    rb     = b;
    @(negedge clk);
    valid  = 1'b0;
  endtask

  // Returns the edge number after which the primary valid pulse was seen, or -1 on timeout.
  task automatic waitValid(output int n);
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (wbValid16 === 1'b1) begin
        n = k;
        return;
      end
    end
  endtask

  task automatic settle(input int cycles);
    for (int k = 0; k < cycles; k++) @(negedge clk);
  endtask

  task automatic test_reset;
    #1;
    nVec++; if (ready16 !== 1'b1) begin nMis++; $display("[TB] FAIL reset_ready: got %b expected 1", ready16); end
    nVec++; if (busy16 !== 1'b0) begin nMis++; $display("[TB] FAIL reset_busy: got %b expected 0", busy16); end
    nVec++; if (wbValid16 !== 1'b0) begin nMis++; $display("[TB] FAIL reset_valid: got %b expected 0", wbValid16); end
    nVec++; if (wbValue16 !== 32'h0) begin nMis++; $display("[TB] FAIL reset_value: got %h expected 00000000", wbValue16); end
    nVec++; if (wbRd16 !== 5'd0) begin nMis++; $display("[TB] FAIL reset_rd: got %0d expected 0", wbRd16); end
    @(negedge clk);
    rstN = 1'b1;
    settle(2);
  endtask

  task automatic test_mulh_min;
    int n;
    issue(7'b0000001, 3'b001, 5'd9, 32'h80000000, 32'h80000000);
    waitValid(n);
    nVec++; if (n !== 5) begin nMis++; $display("[TB] FAIL mulh_min_latency: got %0d expected 5", n); end
    nVec++; if (wbValue16 !== 32'h40000000) begin nMis++; $display("[TB] FAIL mulh_min_value: got %h expected 40000000", wbValue16); end
    nVec++; if (wbRd16 !== 5'd9) begin nMis++; $display("[TB] FAIL mulh_min_rd: got %0d expected 9", wbRd16); end
    @(negedge clk);
    nVec++; if (wbValid16 !== 1'b0) begin nMis++; $display("[TB] FAIL valid_one_cycle: got %b expected 0", wbValid16); end
    nVec++; if (wbValue16 !== 32'h40000000) begin nMis++; $display("[TB] FAIL value_hold: got %h expected 40000000", wbValue16); end
    settle(25);
  endtask

  task automatic test_signs;
    logic [2:0]  f3Tab  [4] = '{3'b000, 3'b011, 3'b010, 3'b001};
    logic [31:0] expTab [4] = '{32'h00000001, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000};
    int n;
    for (int k = 0; k < 4; k++) begin
      issue(7'b0000001, f3Tab[k], 5'(10 + k), 32'hFFFFFFFF, 32'hFFFFFFFF);
      waitValid(n);
      nVec++; if (wbValue16 !== expTab[k]) begin nMis++; $display("[TB] FAIL signs_value_f3_%0d: got %h expected %h", f3Tab[k], wbValue16, expTab[k]); end
      nVec++; if (wbRd16 !== 5'(10 + k)) begin nMis++; $display("[TB] FAIL signs_rd_f3_%0d: got %0d expected %0d", f3Tab[k], wbRd16, 10 + k); end
      settle(25);
    end
  endtask

  task automatic test_slice_sweep;
    int lat8 = -1, lat16 = -1, lat32 = -1;
    int rdyBad8 = 0, rdyBad16 = 0, rdyBad32 = 0;
    issue(7'b0000001, 3'b000, 5'd17, 32'h12345678, 32'h9ABCDEF0);
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (lat8  < 0 && wbValid8  === 1'b1) lat8  = k;
      if (lat16 < 0 && wbValid16 === 1'b1) lat16 = k;
      if (lat32 < 0 && wbValid32 === 1'b1) lat32 = k;
      if (k < 17 && ready8  !== 1'b0) rdyBad8++;
      if (k < 5  && ready16 !== 1'b0) rdyBad16++;
      if (k < 2  && ready32 !== 1'b0) rdyBad32++;
    end
    nVec++; if (lat8 !== 17) begin nMis++; $display("[TB] FAIL sweep8_latency: got %0d expected 17", lat8); end
    nVec++; if (lat16 !== 5) begin nMis++; $display("[TB] FAIL sweep16_latency: got %0d expected 5", lat16); end
    nVec++; if (lat32 !== 2) begin nMis++; $display("[TB] FAIL sweep32_latency: got %0d expected 2", lat32); end
    nVec++; if (wbValue8 !== 32'h242D2080) begin nMis++; $display("[TB] FAIL sweep8_value: got %h expected 242d2080", wbValue8); end
    nVec++; if (wbValue16 !== 32'h242D2080) begin nMis++; $display("[TB] FAIL sweep16_value: got %h expected 242d2080", wbValue16); end
    nVec++; if (wbValue32 !== 32'h242D2080) begin nMis++; $display("[TB] FAIL sweep32_value: got %h expected 242d2080", wbValue32); end
    nVec++; if (rdyBad8 !== 0) begin nMis++; $display("[TB] FAIL sweep8_ready_low: got %0d high cycles expected 0", rdyBad8); end
    nVec++; if (rdyBad16 !== 0) begin nMis++; $display("[TB] FAIL sweep16_ready_low: got %0d high cycles expected 0", rdyBad16); end
    nVec++; if (rdyBad32 !== 0) begin nMis++; $display("[TB] FAIL sweep32_ready_low: got %0d high cycles expected 0", rdyBad32); end
    settle(5);
  endtask

  task automatic test_back_to_back;
    int n;
    issue(7'b0000001, 3'b000, 5'd4, 32'd3, 32'd5);
    waitValid(n);
    nVec++; if (wbValue16 !== 32'd15) begin nMis++; $display("[TB] FAIL b2b_first_value: got %h expected 0000000f", wbValue16); end
    nVec++; if (ready16 !== 1'b1) begin nMis++; $display("[TB] FAIL b2b_ready_in_valid: got %b expected 1", ready16); end
    valid  = 1'b1;
    opcode = {7'b0000001, 5'd2, 5'd1, 3'b011, 5'd3, 7'b0110011};
    rdIdx  = 5'd21;
    ra     = 32'h00010000;
    rb     = 32'h00010000;
    @(negedge clk);
    valid  = 1'b0;
    nVec++; if (busy16 !== 1'b1) begin nMis++; $display("[TB] FAIL b2b_accepted: got busy %b expected 1", busy16); end
    waitValid(n);
    nVec++; if (n !== 5) begin nMis++; $display("[TB] FAIL b2b_latency: got %0d expected 5", n); end
    nVec++; if (wbValue16 !== 32'h00000001) begin nMis++; $display("[TB] FAIL b2b_value: got %h expected 00000001", wbValue16); end
    nVec++; if (wbRd16 !== 5'd21) begin nMis++; $display("[TB] FAIL b2b_rd: got %0d expected 21", wbRd16); end
    settle(25);
  endtask

  task automatic test_flush;
    int pulses = 0;
    logic [31:0] prevValue;
    prevValue = wbValue16;
    issue(7'b0000001, 3'b000, 5'd6, 32'd7, 32'd9);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    nVec++; if (busy16 !== 1'b0) begin nMis++; $display("[TB] FAIL flush_busy: got %b expected 0", busy16); end
    nVec++; if (ready16 !== 1'b1) begin nMis++; $display("[TB] FAIL flush_ready: got %b expected 1", ready16); end
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (wbValid16 === 1'b1) pulses++;
    end
    nVec++; if (pulses !== 0) begin nMis++; $display("[TB] FAIL flush_no_pulse: got %0d pulses expected 0", pulses); end
    nVec++; if (wbValue16 !== prevValue) begin nMis++; $display("[TB] FAIL flush_value_kept: got %h expected %h", wbValue16, prevValue); end
    // flush while idle must block a simultaneous request
    valid  = 1'b1;
    flush  = 1'b1;
    opcode = {7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
    @(negedge clk);
    valid  = 1'b0;
    flush  = 1'b0;
    nVec++; if (busy16 !== 1'b0) begin nMis++; $display("[TB] FAIL flush_idle_block: got busy %b expected 0", busy16); end
    settle(3);
  endtask

  task automatic test_reset_mid;
    int pulses = 0;
    issue(7'b0000001, 3'b011, 5'd30, 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(negedge clk);
    rstN = 1'b0;
    #1;
    nVec++; if (wbValue16 !== 32'h0) begin nMis++; $display("[TB] FAIL rst_mid_value: got %h expected 00000000", wbValue16); end
    nVec++; if (wbRd16 !== 5'd0) begin nMis++; $display("[TB] FAIL rst_mid_rd: got %0d expected 0", wbRd16); end
    nVec++; if (wbValid16 !== 1'b0) begin nMis++; $display("[TB] FAIL rst_mid_valid: got %b expected 0", wbValid16); end
    nVec++; if (busy16 !== 1'b0) begin nMis++; $display("[TB] FAIL rst_mid_busy: got %b expected 0", busy16); end
    nVec++; if (ready16 !== 1'b1) begin nMis++; $display("[TB] FAIL rst_mid_ready: got %b expected 1", ready16); end
    @(negedge clk);
    rstN = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (wbValid16 === 1'b1 || wbValid8 === 1'b1 || wbValid32 === 1'b1) pulses++;
    end
    nVec++; if (pulses !== 0) begin nMis++; $display("[TB] FAIL rst_mid_no_pulse: got %0d pulses expected 0", pulses); end
  endtask

  task automatic test_non_mul;
    int busyCycles = 0, pulses = 0;
    issue(7'b0000000, 3'b000, 5'd5, 32'd2, 32'd3);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (busy16 !== 1'b0) busyCycles++;
      if (wbValid16 === 1'b1) pulses++;
    end
    issue(7'b0000001, 3'b100, 5'd5, 32'd20, 32'd4);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (busy16 !== 1'b0) busyCycles++;
      if (wbValid16 === 1'b1) pulses++;
    end
    nVec++; if (busyCycles !== 0) begin nMis++; $display("[TB] FAIL nonmul_busy: got %0d busy cycles expected 0", busyCycles); end
    nVec++; if (pulses !== 0) begin nMis++; $display("[TB] FAIL nonmul_pulse: got %0d pulses expected 0", pulses); end
    nVec++; if (wbValue16 !== 32'h0) begin nMis++; $display("[TB] FAIL nonmul_value: got %h expected 00000000", wbValue16); end
  endtask

  initial begin
    test_reset();
    test_mulh_min();
    test_signs();
    test_slice_sweep();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_non_mul();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
